// File: rtl/inv_sub_bytes_iter.sv
// inv_sub_bytes_iter: iterative AES InvSubBytes over a 128-bit state.
// LANES bytes are substituted per cycle, so a block takes 16/LANES cycles.
// Optional build macro INV_SUB_BYTES_DUAL_EN adds a per-block decrypt select
// with a forward S-box beside each inverse S-box.
// The S-boxes are computed arithmetically: GF(2^8) inverse plus the AES affine map.

package inv_sub_bytes_pkg;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0.
  function automatic logic [7:0] gfInv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gfMul(sq, sq);
      r  = gfMul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sboxFwd(input logic [7:0] a);
    logic [7:0] b;
    b = gfInv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sboxInv(input logic [7:0] a);
    return gfInv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

endpackage

// Inverse S-box, combinational.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = inv_sub_bytes_pkg::sboxInv(a);
endmodule

`ifdef INV_SUB_BYTES_DUAL_EN
// Forward S-box, combinational.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = inv_sub_bytes_pkg::sboxFwd(a);
endmodule
`endif

module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] bytesIn,
`ifdef INV_SUB_BYTES_DUAL_EN
  input  logic         decrypt,
`endif
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] bytesOut,
  output logic         busy
);

  localparam int STEPS = 16 / LANES;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gBadLanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsmState;

  fsmState          state;
  fsmState          stateNext;
  logic [CW-1:0]    step;
  logic [15:0][7:0] work;     // element 15 is byte 0 (bits 127:120)
  logic [15:0][7:0] workSub;
  logic [3:0]       laneIdx [LANES];
  logic [7:0]       laneOut [LANES];
  logic             accept;
  logic             handoff;
  logic             lastStep;
`ifdef INV_SUB_BYTES_DUAL_EN
  logic             decMode;
`endif

  assign accept   = inValid && inReady;
  assign handoff  = outValid && outReady;
  assign lastStep = (step == CW'(STEPS - 1));

  // One substitution lane per S-box; lane l handles byte step*LANES+l.
  for (genvar l = 0; l < LANES; l++) begin : gLane
    logic [7:0] invOut;
    assign laneIdx[l] = 4'(15 - (int'(step) * LANES + l));
    inv_sbox uInv (.a(work[laneIdx[l]]), .y(invOut));
`ifdef INV_SUB_BYTES_DUAL_EN
    logic [7:0] fwdOut;
    sbox uFwd (.a(work[laneIdx[l]]), .y(fwdOut));
    assign laneOut[l] = decMode ? invOut : fwdOut;
`else
    assign laneOut[l] = invOut;
`endif
  end

  // Merge this step's substituted lanes back into the work value.
  always_comb begin
    // NOTE: default first so every path assigns workSub and no latch is inferred.
    workSub = work;
    for (int l = 0; l < LANES; l++) workSub[laneIdx[l]] = laneOut[l];
  end

  // Next-state logic for the IDLE -> BUSY -> DONE loop.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (accept)   stateNext = BUSY;
      BUSY:    if (lastStep) stateNext = DONE;
      DONE:    if (handoff)  stateNext = IDLE;
      default:               stateNext = IDLE;
    endcase
  end

  // State register with registered handshake flags derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state    <= IDLE;
      inReady  <= 1'b0;
      outValid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= stateNext;
      inReady  <= (stateNext == IDLE);
      outValid <= (stateNext == DONE);
      busy     <= (stateNext != IDLE);
    end
  end

  // Datapath: latch on accept, substitute one slice per BUSY cycle, publish at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the work register is reset so an aborted block can never leak into bytesOut.
      work     <= '0;
      step     <= '0;
      bytesOut <= '0;
`ifdef INV_SUB_BYTES_DUAL_EN
      decMode  <= 1'b1;
`endif
    end else if (accept) begin
      work     <= bytesIn;
      step     <= '0;
`ifdef INV_SUB_BYTES_DUAL_EN
      decMode  <= decrypt;
`endif
    end else if (state == BUSY) begin
      work <= workSub;
      if (lastStep) bytesOut <= workSub;
      else          step     <= step + 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: five instances (LANES 1, 2, 4, 8, 16) share
// one stimulus stream; each is checked against a table-driven reference.
module tb_inv_sub_bytes_iter;

  localparam int NI = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         inValid;
  logic         outReady;
  logic [127:0] bytesIn;
  logic         inReadyV  [NI];
  logic         outValidV [NI];
  logic         busyV     [NI];
  logic [127:0] bytesOutV [NI];
`ifdef INV_SUB_BYTES_DUAL_EN
  logic         decrypt;
`endif

  int passCnt  = 0;
  int checkCnt = 0;
  int failCnt  = 0;

  logic [7:0] fwdTab [256];
  logic [7:0] invTab [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gDut
    inv_sub_bytes_iter #(.LANES(1 << g)) dut (
      .clk      (clk),
      .rst      (rst),
      .inValid  (inValid),
      .inReady  (inReadyV[g]),
      .bytesIn  (bytesIn),
`ifdef INV_SUB_BYTES_DUAL_EN
      .decrypt  (decrypt),
`endif
      .outValid (outValidV[g]),
      .outReady (outReady),
      .bytesOut (bytesOutV[g]),
      .busy     (busyV[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    check(tag, 128'(obs), 128'(exp));
  endtask

  // S-box table from the generator walk (p multiplied by 3, q divided by 3).
  task automatic buildTables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      fwdTab[p] = x ^ 8'h63;
    end while (p != 8'h01);
    fwdTab[0] = 8'h63;
    for (int i = 0; i < 256; i++) invTab[fwdTab[i]] = 8'(i);
  endtask

  function automatic logic [127:0] refSub(input logic [127:0] d, input bit dec);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      b = d[127 - 8*k -: 8];
      r[127 - 8*k -: 8] = dec ? invTab[b] : fwdTab[b];
    end
    return r;
  endfunction

  function automatic bit allReady();
    for (int g = 0; g < NI; g++) if (inReadyV[g] !== 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic waitAllReady();
    int n;
    n = 0;
    while (!allReady() && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkBit("wait_ready", allReady(), 1'b1);
  endtask

  // One block through all instances with outReady held high.
  task automatic runAll(input logic [127:0] data, input logic [127:0] exp, input bit toggleIn);
    int firstK  [NI];
    int highCnt [NI];
    waitAllReady();
    for (int g = 0; g < NI; g++) begin
      firstK[g]  = -1;
      highCnt[g] = 0;
    end
    bytesIn  = data;
    inValid  = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    for (int g = 0; g < NI; g++)
      checkBit($sformatf("busy_after_accept_L%0d", 1 << g), busyV[g], 1'b1);
    for (int k = 1; k <= 18; k++) begin
      if (toggleIn) bytesIn = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        if (outValidV[g] === 1'b1) begin
          if (firstK[g] < 0) firstK[g] = k;
          highCnt[g]++;
          check($sformatf("data_L%0d", 1 << g), bytesOutV[g], exp);
        end
      end
    end
    for (int g = 0; g < NI; g++) begin
      check($sformatf("latency_L%0d", 1 << g), 128'(firstK[g]), 128'(16 >> g));
      check($sformatf("valid_cycles_L%0d", 1 << g), 128'(highCnt[g]), 128'(1));
      checkBit($sformatf("ready_after_L%0d", 1 << g), inReadyV[g], 1'b1);
      checkBit($sformatf("idle_busy_L%0d", 1 << g), busyV[g], 1'b0);
      check($sformatf("retained_L%0d", 1 << g), bytesOutV[g], exp);
    end
  endtask

  initial begin
    automatic logic [127:0] d1;
    automatic logic [127:0] d2;
    automatic logic [127:0] e1;
    buildTables();
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    bytesIn  = '0;
`ifdef INV_SUB_BYTES_DUAL_EN
    decrypt  = 1'b1;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checkBit($sformatf("rst_inReady_L%0d", 1 << g), inReadyV[g], 1'b0);
      checkBit($sformatf("rst_outValid_L%0d", 1 << g), outValidV[g], 1'b0);
      checkBit($sformatf("rst_busy_L%0d", 1 << g), busyV[g], 1'b0);
      check($sformatf("rst_bytesOut_L%0d", 1 << g), bytesOutV[g], '0);
    end
    rst = 1'b0;
    #1;
    for (int g = 0; g < NI; g++)
      checkBit($sformatf("release_inReady_L%0d", 1 << g), inReadyV[g], 1'b0);
    @(negedge clk);
    for (int g = 0; g < NI; g++)
      checkBit($sformatf("first_edge_inReady_L%0d", 1 << g), inReadyV[g], 1'b1);

    // Known vectors.
    runAll(128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    runAll('0, {16{8'h52}}, 1'b0);
    runAll({16{8'h16}}, {16{8'hff}}, 1'b0);

    // Input toggling during BUSY must not disturb the result.
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    runAll(d1, refSub(d1, 1'b1), 1'b1);

    // Output stall: hold outReady low, pulse a foreign block, then release.
    waitAllReady();
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    d2 = ~d1;
    e1 = refSub(d1, 1'b1);
    bytesIn  = d1;
    inValid  = 1'b1;
    outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    repeat (16) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        bytesIn = d2;
        inValid = 1'b1;
      end else begin
        inValid = 1'b0;
      end
      @(negedge clk);
      for (int g = 0; g < NI; g++) begin
        checkBit($sformatf("stall_valid_L%0d_c%0d", 1 << g, c), outValidV[g], 1'b1);
        check($sformatf("stall_data_L%0d_c%0d", 1 << g, c), bytesOutV[g], e1);
        checkBit($sformatf("stall_ready_L%0d_c%0d", 1 << g, c), inReadyV[g], 1'b0);
      end
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      checkBit($sformatf("handoff_valid_L%0d", 1 << g), outValidV[g], 1'b0);
      checkBit($sformatf("handoff_ready_L%0d", 1 << g), inReadyV[g], 1'b1);
      checkBit($sformatf("handoff_busy_L%0d", 1 << g), busyV[g], 1'b0);
      check($sformatf("handoff_keep_L%0d", 1 << g), bytesOutV[g], e1);
    end
    runAll(d2, refSub(d2, 1'b1), 1'b0);

    // Reset abort at step 2 of the LANES=4 instance.
    waitAllReady();
    bytesIn  = 128'h0123456789abcdeffedcba9876543210;
    inValid  = 1'b1;
    outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    repeat (2) @(negedge clk);
    checkBit("pre_abort_valid_L16", outValidV[4], 1'b1);
    rst = 1'b1;
    #1;
    for (int g = 0; g < NI; g++) begin
      checkBit($sformatf("abort_valid_L%0d", 1 << g), outValidV[g], 1'b0);
      checkBit($sformatf("abort_busy_L%0d", 1 << g), busyV[g], 1'b0);
      check($sformatf("abort_data_L%0d", 1 << g), bytesOutV[g], '0);
      checkBit($sformatf("abort_ready_L%0d", 1 << g), inReadyV[g], 1'b0);
    end
    @(negedge clk);
    rst      = 1'b0;
    outReady = 1'b1;
    @(negedge clk);
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    runAll(d1, refSub(d1, 1'b1), 1'b0);

    // Random blocks, alternating quiet and toggling input.
    for (int i = 0; i < 6; i++) begin
      d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      runAll(d1, refSub(d1, 1'b1), i[0]);
    end

`ifdef INV_SUB_BYTES_DUAL_EN
    // Forward mode and round trip.
    decrypt = 1'b0;
    runAll(128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76, 1'b0);
    d1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    e1 = refSub(d1, 1'b0);
    runAll(d1, e1, 1'b0);
    decrypt = 1'b1;
    runAll(e1, d1, 1'b0);
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
